// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Carries the request handshake (address, write enable, lane data and strobes)
// and the response (load data / store acknowledge).
interface mem_stage_if #(
    parameter int XLEN = 64
);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [XLEN-1:0]   dmem_req_addr;
    logic              dmem_req_we;
    logic [XLEN-1:0]   dmem_req_wdata;
    logic [XLEN/8-1:0] dmem_req_wstrb;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_resp_rdata;

    modport master (
        output dmem_req_valid,
        input  dmem_req_ready,
        output dmem_req_addr,
        output dmem_req_we,
        output dmem_req_wdata,
        output dmem_req_wstrb,
        input  dmem_resp_valid,
        input  dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid,
        output dmem_req_ready,
        input  dmem_req_addr,
        input  dmem_req_we,
        input  dmem_req_wdata,
        input  dmem_req_wstrb,
        output dmem_resp_valid,
        output dmem_resp_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage core (between EX and WB).
// Holds one instruction, runs the data-memory request/response handshake for
// loads and stores, drives the `me` forwarding port from the held state and the
// `wb` commit port through a one-cycle register.
module mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,

    // EX -> MEM
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_en,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [1:0]      ex_size,
    input  logic            ex_unsigned,
    input  logic [XLEN-1:0] ex_store_data,

    // Data memory
    mem_stage_if.master     dmem,

    // Forwarding port
    output logic [4:0]      me_rd,
    output logic            me_rd_en,
    output logic            me_rd_forward,
    output logic [XLEN-1:0] me_rd_value,

    // Commit port
    output logic [4:0]      wb_rd,
    output logic            wb_rd_en,
    output logic [XLEN-1:0] wb_rd_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_READY = 2'd3
    } state_e;

    state_e            state_q;
    logic [4:0]        rd_q;
    logic              rd_en_q;
    logic              is_load_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [XLEN-1:0]   addr_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN/8-1:0] wstrb_q;
    logic [XLEN-1:0]   value_q;

    logic [4:0]        wb_rd_q;
    logic              wb_rd_en_q;
    logic [XLEN-1:0]   wb_value_q;

    logic              accept;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN/8-1:0] wstrb_d;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   load_value_d;

    assign ex_ready = (state_q == S_IDLE) || (state_q == S_READY);
    assign accept   = ex_valid && ex_ready;

    // Store lane generation: replicate the low bytes and place the strobes at the byte offset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wdata_d = '0;
        wstrb_d = '0;
        unique case (ex_size)
            2'd0: begin
                wdata_d = {8{ex_store_data[7:0]}};
                wstrb_d = 8'h01 << ex_result[2:0];
            end
            2'd1: begin
                wdata_d = {4{ex_store_data[15:0]}};
                wstrb_d = 8'h03 << ex_result[2:0];
            end
            2'd2: begin
                wdata_d = {2{ex_store_data[31:0]}};
                wstrb_d = 8'h0F << ex_result[2:0];
            end
            default: begin
                wdata_d = ex_store_data;
                wstrb_d = 8'hFF << ex_result[2:0];
            end
        endcase
    end

    // Load lane extraction: shift the addressed bytes down, then sign- or zero-extend.
    always_comb begin
        lane         = dmem.dmem_resp_rdata >> {addr_q[2:0], 3'b000};
        load_value_d = '0;
        unique case (size_q)
            2'd0: load_value_d = unsigned_q ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1: load_value_d = unsigned_q ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2: load_value_d = unsigned_q ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_value_d = lane;
        endcase
    end

    // Stage FSM with held instruction fields and the one-cycle commit register.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the held datapath registers are reset too, because every data output must read 0 after reset.
            state_q    <= S_IDLE;
            rd_q       <= '0;
            rd_en_q    <= 1'b0;
            is_load_q  <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            value_q    <= '0;
            wb_rd_q    <= '0;
            wb_rd_en_q <= 1'b0;
            wb_value_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            wb_rd_en_q <= (state_q == S_READY) && rd_en_q;
            wb_rd_q    <= rd_q;
            wb_value_q <= value_q;

            unique case (state_q)
                S_IDLE, S_READY: begin
                    if (accept) begin
                        rd_q       <= ex_rd;
                        rd_en_q    <= ex_rd_en;
                        is_load_q  <= ex_is_load;
                        size_q     <= ex_size;
                        unsigned_q <= ex_unsigned;
                        addr_q     <= ex_result;
                        we_q       <= ex_is_store;
                        wdata_q    <= ex_is_store ? wdata_d : '0;
                        wstrb_q    <= ex_is_store ? wstrb_d : '0;
                        value_q    <= ex_result;
                        state_q    <= (ex_is_load || ex_is_store) ? S_REQ : S_READY;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_resp_valid) begin
                        if (is_load_q) begin
                            value_q <= load_value_d;
                        end
                        state_q <= S_READY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req_valid = (state_q == S_REQ);
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_wstrb = wstrb_q;

    assign me_rd         = rd_q;
    assign me_rd_en      = (state_q != S_IDLE) && rd_en_q;
    assign me_rd_forward = (state_q == S_READY);
    assign me_rd_value   = value_q;

    assign wb_rd       = wb_rd_q;
    assign wb_rd_en    = wb_rd_en_q;
    assign wb_rd_value = wb_value_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads of every width and
// sign, a half-word store, back-to-back ALU ops, reset during WAIT, rd==0 load.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_rd_en;
    logic [63:0] ex_result;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [63:0] ex_store_data;
    logic [4:0]  me_rd;
    logic        me_rd_en;
    logic        me_rd_forward;
    logic [63:0] me_rd_value;
    logic [4:0]  wb_rd;
    logic        wb_rd_en;
    logic [63:0] wb_rd_value;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_stage_if #(.XLEN(64)) dmem_bus ();

    mem_stage #(.XLEN(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_rd         (ex_rd),
        .ex_rd_en      (ex_rd_en),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_store_data (ex_store_data),
        .dmem          (dmem_bus.master),
        .me_rd         (me_rd),
        .me_rd_en      (me_rd_en),
        .me_rd_forward (me_rd_forward),
        .me_rd_value   (me_rd_value),
        .wb_rd         (wb_rd),
        .wb_rd_en      (wb_rd_en),
        .wb_rd_value   (wb_rd_value)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_op(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [4:0] rd, input logic rd_en,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input logic [63:0] exp_val,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                          input int ready_delay, input int resp_delay);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_rd_en      = rd_en;
        ex_result     = addr;
        ex_is_load    = ld;
        ex_is_store   = !ld;
        ex_size       = sz;
        ex_unsigned   = uns;
        ex_store_data = sdata;
        dmem_bus.dmem_req_ready = 1'b0;
        step();
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        // A stray response while still in REQ must be ignored.
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < ready_delay; i++) begin
            check("req.valid",   {63'b0, dmem_bus.dmem_req_valid}, 64'd1);
            check("req.addr",    dmem_bus.dmem_req_addr, addr);
            check("req.we",      {63'b0, dmem_bus.dmem_req_we}, {63'b0, !ld});
            check("req.wstrb",   {56'b0, dmem_bus.dmem_req_wstrb}, {56'b0, exp_strb});
            if (!ld) check("req.wdata", dmem_bus.dmem_req_wdata, exp_wdata);
            check("req.me_en",   {63'b0, me_rd_en}, {63'b0, rd_en});
            check("req.me_fwd",  {63'b0, me_rd_forward}, 64'd0);
            check("req.ex_ready",{63'b0, ex_ready}, 64'd0);
            step();
            dmem_bus.dmem_resp_valid = 1'b0;
        end
        check("req.final_valid", {63'b0, dmem_bus.dmem_req_valid}, 64'd1);
        check("req.final_addr",  dmem_bus.dmem_req_addr, addr);
        dmem_bus.dmem_req_ready = 1'b1;
        step();
        dmem_bus.dmem_req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            check("wait.req_valid", {63'b0, dmem_bus.dmem_req_valid}, 64'd0);
            check("wait.me_fwd",    {63'b0, me_rd_forward}, 64'd0);
            check("wait.me_en",     {63'b0, me_rd_en}, {63'b0, rd_en});
            check("wait.ex_ready",  {63'b0, ex_ready}, 64'd0);
            step();
        end
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_resp_rdata = rdata;
        step();
        dmem_bus.dmem_resp_valid = 1'b0;
        dmem_bus.dmem_resp_rdata = '0;
        check("ready.me_fwd",    {63'b0, me_rd_forward}, 64'd1);
        check("ready.ex_ready",  {63'b0, ex_ready}, 64'd1);
        check("ready.req_valid", {63'b0, dmem_bus.dmem_req_valid}, 64'd0);
        check("ready.wb_en",     {63'b0, wb_rd_en}, 64'd0);
        if (ld) check("ready.me_value", me_rd_value, exp_val);
        step();
        check("commit.wb_en", {63'b0, wb_rd_en}, {63'b0, rd_en});
        if (rd_en) begin
            check("commit.wb_rd", {59'b0, wb_rd}, {59'b0, rd});
            check("commit.wb_value", wb_rd_value, exp_val);
        end
        check("commit.me_en",    {63'b0, me_rd_en}, 64'd0);
        check("commit.ex_ready", {63'b0, ex_ready}, 64'd1);
        step();
        check("after.wb_en", {63'b0, wb_rd_en}, 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_rd         = '0;
        ex_rd_en      = 1'b0;
        ex_result     = '0;
        ex_is_load    = 1'b0;
        ex_is_store   = 1'b0;
        ex_size       = '0;
        ex_unsigned   = 1'b0;
        ex_store_data = '0;
        dmem_bus.dmem_req_ready  = 1'b0;
        dmem_bus.dmem_resp_valid = 1'b0;
        dmem_bus.dmem_resp_rdata = '0;
        step();
        step();

        // Reset state
        check("rst.ex_ready",  {63'b0, ex_ready}, 64'd1);
        check("rst.req_valid", {63'b0, dmem_bus.dmem_req_valid}, 64'd0);
        check("rst.req_addr",  dmem_bus.dmem_req_addr, 64'd0);
        check("rst.me_en",     {63'b0, me_rd_en}, 64'd0);
        check("rst.me_fwd",    {63'b0, me_rd_forward}, 64'd0);
        check("rst.me_value",  me_rd_value, 64'd0);
        check("rst.wb_en",     {63'b0, wb_rd_en}, 64'd0);
        check("rst.wb_value",  wb_rd_value, 64'd0);
        reset = 1'b0;
        step();

        // ALU op rd=5 result=0x1234
        ex_valid  = 1'b1;
        ex_rd     = 5'd5;
        ex_rd_en  = 1'b1;
        ex_result = 64'h1234;
        check("alu.ex_ready", {63'b0, ex_ready}, 64'd1);
        step();
        ex_valid = 1'b0;
        check("alu.me_en",    {63'b0, me_rd_en}, 64'd1);
        check("alu.me_fwd",   {63'b0, me_rd_forward}, 64'd1);
        check("alu.me_rd",    {59'b0, me_rd}, 64'd5);
        check("alu.me_value", me_rd_value, 64'h1234);
        check("alu.wb_en0",   {63'b0, wb_rd_en}, 64'd0);
        step();
        check("alu.wb_en",    {63'b0, wb_rd_en}, 64'd1);
        check("alu.wb_rd",    {59'b0, wb_rd}, 64'd5);
        check("alu.wb_value", wb_rd_value, 64'h1234);
        check("alu.idle_me_en", {63'b0, me_rd_en}, 64'd0);
        step();
        check("alu.wb_en_drop", {63'b0, wb_rd_en}, 64'd0);

        // lb rd=7 @0x1003: byte 3 of 0x80000000 is 0x80 -> sign-extended
        mem_op(1'b1, 2'd0, 1'b0, 5'd7, 1'b1, 64'h1003, 64'd0,
               64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80,
               8'h00, 64'd0, 2, 3);
        // lbu same access -> zero-extended
        mem_op(1'b1, 2'd0, 1'b1, 5'd7, 1'b1, 64'h1003, 64'd0,
               64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080,
               8'h00, 64'd0, 2, 3);
        // lw @0x4004: upper word 0x89ABCDEF sign-extended
        mem_op(1'b1, 2'd2, 1'b0, 5'd9, 1'b1, 64'h4004, 64'd0,
               64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF,
               8'h00, 64'd0, 1, 0);
        // lhu @0x5002: half at bytes 2..3 zero-extended
        mem_op(1'b1, 2'd1, 1'b1, 5'd10, 1'b1, 64'h5002, 64'd0,
               64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D,
               8'h00, 64'd0, 1, 1);
        // sh 0xABCD @0x2006: strobes on bytes 6..7, data replicated; no writeback
        mem_op(1'b0, 2'd1, 1'b0, 5'd0, 1'b0, 64'h2006, 64'h0000_0000_0000_ABCD,
               64'd0, 64'd0, 8'hC0, 64'hABCD_ABCD_ABCD_ABCD, 1, 2);
        // ld rd=0 @0x3000: full double, rd 0 still pulses wb
        mem_op(1'b1, 2'd3, 1'b0, 5'd0, 1'b1, 64'h3000, 64'd0,
               64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
               8'h00, 64'd0, 1, 1);

        // Three back-to-back ALU ops
        ex_valid  = 1'b1;
        ex_rd_en  = 1'b1;
        ex_rd     = 5'd1;
        ex_result = 64'h11;
        step();
        check("b2b.ex_ready1", {63'b0, ex_ready}, 64'd1);
        check("b2b.wb_en0",    {63'b0, wb_rd_en}, 64'd0);
        ex_rd     = 5'd2;
        ex_result = 64'h22;
        step();
        check("b2b.ex_ready2", {63'b0, ex_ready}, 64'd1);
        check("b2b.wb_en1",    {63'b0, wb_rd_en}, 64'd1);
        check("b2b.wb_value1", wb_rd_value, 64'h11);
        check("b2b.wb_rd1",    {59'b0, wb_rd}, 64'd1);
        check("b2b.me_value2", me_rd_value, 64'h22);
        ex_rd     = 5'd3;
        ex_result = 64'h33;
        step();
        ex_valid = 1'b0;
        check("b2b.ex_ready3", {63'b0, ex_ready}, 64'd1);
        check("b2b.wb_en2",    {63'b0, wb_rd_en}, 64'd1);
        check("b2b.wb_value2", wb_rd_value, 64'h22);
        step();
        check("b2b.wb_en3",    {63'b0, wb_rd_en}, 64'd1);
        check("b2b.wb_value3", wb_rd_value, 64'h33);
        check("b2b.wb_rd3",    {59'b0, wb_rd}, 64'd3);
        check("b2b.idle_fwd",  {63'b0, me_rd_forward}, 64'd0);
        step();
        check("b2b.wb_en_end", {63'b0, wb_rd_en}, 64'd0);

        // Reset while a load is in WAIT, then a late response
        ex_valid    = 1'b1;
        ex_rd       = 5'd12;
        ex_rd_en    = 1'b1;
        ex_result   = 64'h6000;
        ex_is_load  = 1'b1;
        ex_size     = 2'd3;
        ex_unsigned = 1'b0;
        step();
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        dmem_bus.dmem_req_ready = 1'b1;
        step();
        dmem_bus.dmem_req_ready = 1'b0;
        check("rw.wait_me_en",  {63'b0, me_rd_en}, 64'd1);
        check("rw.wait_fwd",    {63'b0, me_rd_forward}, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        dmem_bus.dmem_resp_valid = 1'b1;
        dmem_bus.dmem_resp_rdata = 64'hCAFE_F00D_CAFE_F00D;
        step();
        dmem_bus.dmem_resp_valid = 1'b0;
        check("rw.ex_ready",  {63'b0, ex_ready}, 64'd1);
        check("rw.req_valid", {63'b0, dmem_bus.dmem_req_valid}, 64'd0);
        check("rw.req_addr",  dmem_bus.dmem_req_addr, 64'd0);
        check("rw.me_en",     {63'b0, me_rd_en}, 64'd0);
        check("rw.me_fwd",    {63'b0, me_rd_forward}, 64'd0);
        check("rw.me_value",  me_rd_value, 64'd0);
        check("rw.wb_en",     {63'b0, wb_rd_en}, 64'd0);
        check("rw.wb_value",  wb_rd_value, 64'd0);
        step();
        check("rw.wb_en_later", {63'b0, wb_rd_en}, 64'd0);
        check("rw.fwd_later",   {63'b0, me_rd_forward}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage of the 5-stage core. Sits between EX and WB.
- Holds one instruction and performs the data-memory request/response handshake for loads and stores.
- Drives the master side of the `me` GPR forwarding port, which the register file uses for bypass and busy detection.
- Drives the master side of the `wb` GPR commit port through a one-cycle WB register.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_rd  in  5  destination register
- ex_rd_en  in  1  instruction writes rd
- ex_result  in  64  ALU result; effective address for load/store
- ex_is_load  in  1  load instruction
- ex_is_store  in  1  store instruction
- ex_size  in  2  0=byte, 1=half, 2=word, 3=double
- ex_unsigned  in  1  zero-extend the load result
- ex_store_data  in  64  store data (rs2)
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts the request
- dmem_req_addr  out  64  byte address
- dmem_req_we  out  1  1=store
- dmem_req_wdata  out  64  store data replicated across byte lanes
- dmem_req_wstrb  out  8  byte enables
- dmem_resp_valid  in  1  response valid (load data / store acknowledge)
- dmem_resp_rdata  in  64  aligned 8-byte read data
- me_rd  out  5  forward port: held rd
- me_rd_en  out  1  forward port: held instruction writes rd
- me_rd_forward  out  1  forward port: me_rd_value is final
- me_rd_value  out  64  forward port: result value
- wb_rd  out  5  commit port: rd
- wb_rd_en  out  1  commit port: write enable
- wb_rd_value  out  64  commit port: write value

Behaviour:
- State machine states: IDLE (empty), REQ, WAIT, READY. Stage valid means state != IDLE.
- Handshake: ex_ready = (state==IDLE) || (state==READY). On ex_valid && ex_ready, the instruction is captured.
  - Load or store: next state REQ.
  - Otherwise: next state READY, with value = ex_result.
- REQ:
  - dmem_req_valid=1, and addr/we/wdata/wstrb are held stable until dmem_req_ready.
  - On ready, go to WAIT.
  - A response is never expected in the handshake cycle.
- WAIT:
  - dmem_resp_valid is ignored in any other state.
  - On resp for a store, go to READY.
  - On resp for a load: select the lane at dmem_resp_rdata[addr[2:0]*8 +: 8<<size], sign- or zero-extend it to 64 bits, latch it as value, and go to READY.
- READY: the instruction leaves at the next edge.
  - If a new instruction is accepted in the same cycle, it replaces the old one with no bubble.
  - Otherwise, go to IDLE.
- Store lanes: wstrb = ((1<<(1<<size))-1) << addr[2:0]. wdata = store_data low (8<<size) bits replicated across all 8 bytes.
- Alignment: accesses are naturally aligned by ISA trap handling upstream. Misaligned requests are not generated.
- Forward port (combinational from state):
  - me_rd = held rd.
  - me_rd_en = valid && held rd_en.
  - me_rd_forward = (state==READY).
  - me_rd_value = held value.
  - While a load is in REQ/WAIT: me_rd_en=1 and me_rd_forward=0, so ID stalls on a dependent read.
- Commit port (registered): at each edge, wb_rd_en <= (state==READY) && held rd_en; wb_rd <= held rd; wb_rd_value <= held value.
  - wb_rd_en is high exactly one cycle per retiring writer.
  - rd==0 is passed through; the register file discards it.
- Reset:
  - state=IDLE.
  - All outputs 0: ex_ready=1 after reset, dmem_req_valid=0, me_rd_en=0, me_rd_forward=0, wb_rd_en=0, all data outputs 0.
  - Reset during REQ/WAIT abandons the access. A late dmem_resp_valid after reset is ignored because the state is not WAIT.
- Back-pressure: ex_ready=0 in REQ/WAIT. EX holds its outputs.

Test Plan:
- ALU op rd=5, result=0x1234, rd_en=1 accepted at cycle 0 -> cycle 1: me_rd_en=1, me_rd_forward=1, me_rd_value=0x1234; cycle 2: wb_rd_en=1, wb_rd=5, wb_rd_value=0x1234.
- lb rd=7, addr=0x1003, resp_rdata=0x00000000_80000000 with ready delayed 2 cycles and resp 3 cycles after -> dmem_req_valid held with stable addr; me_rd_forward=0 until READY; then value=0xFFFFFFFF_FFFFFF80; one wb pulse. Repeat as lbu -> 0x80.
- sh data=0xABCD, addr=0x2006 -> wstrb=0xC0, wdata=0xABCDABCD_ABCDABCD, we=1; after resp: READY, wb_rd_en=0.
- Three back-to-back ALU ops -> ex_ready stays 1; wb_rd_en high for 3 consecutive cycles with values in order.
- Load in WAIT, reset asserted 1 cycle, then resp_valid pulse -> all outputs 0, state IDLE, no wb pulse, ex_ready=1.
- ld rd=0 -> memory access performed; wb_rd_en=1 with wb_rd=0 (discarded by the register file).
